moon_hit_ctrl: RTL

// - Downstream consumer of the moon enemy: each frame, tests player vs moon overlap,

---
 rtl/stg_pkg.sv | 28 ++
 rtl/moon_hit_ctrl_if.sv | 37 +++
 rtl/moon_hit_cmp.sv | 52 +++++
 rtl/moon_hit_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/stg_pkg.sv
// Shared types and constants for the moon hit controller slice.
// State encoding, playfield limits, widths and the saturating speed add.
package stg_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        OVER   = 2'd2
    } state_t;

    localparam int CW       = 10;
    localparam int MAX_X    = 384;
    localparam int MAX_Y    = 448;
    localparam int TIME_MAX = 2000000;
    localparam int SPD_W    = 26;
    localparam int LIV_W    = 3;

    function automatic logic [SPD_W-1:0] sat_add(
        input logic [SPD_W-1:0] a,
        input logic [SPD_W-1:0] b,
        input logic [SPD_W-1:0] lim
    );
        logic [SPD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/moon_hit_ctrl_if.sv
// Bundle between the sprite units, the hit controller and the HUD.
// master drives positions and strobes, slave returns game status.
interface moon_hit_ctrl_if;
    import stg_pkg::*;

    logic             frame_tick;
    logic             restart;
    logic [CW-1:0]    player_x;
    logic [CW-1:0]    player_y;
    logic [CW-1:0]    moon_x;
    logic [CW-1:0]    moon_y;
    logic             moon_on;
    logic             player_on;
    logic             hit_pulse;
    logic [LIV_W-1:0] lives;
    logic             invuln;
    logic             player_blink;
    logic             game_over;
    logic [SPD_W-1:0] speed_offset;

    modport master (
        output frame_tick, restart,
        output player_x, player_y, moon_x, moon_y,
        output moon_on, player_on,
        input  hit_pulse, lives, invuln,
        input  player_blink, game_over, speed_offset
    );

    modport slave (
        input  frame_tick, restart,
        input  player_x, player_y, moon_x, moon_y,
        input  moon_on, player_on,
        output hit_pulse, lives, invuln,
        output player_blink, game_over, speed_offset
    );

endinterface

// File: rtl/moon_hit_cmp.sv
// Box overlap test: registers |dx|,|dy| on the accepted tick, then
// compares them against the combined half-sides in the following cycle.
module moon_hit_cmp
    import stg_pkg::*;
#(
    parameter int HIT_RADIUS    = 40,
    parameter int PLAYER_RADIUS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          flush,
    input  logic [CW-1:0] player_x,
    input  logic [CW-1:0] player_y,
    input  logic [CW-1:0] moon_x,
    input  logic [CW-1:0] moon_y,
    output logic          valid,
    output logic          collide
);

    localparam logic [CW-1:0] LIM = CW'(HIT_RADIUS + PLAYER_RADIUS);

    logic signed [CW:0] dx;
    logic signed [CW:0] dy;
    logic [CW-1:0]      adx;
    logic [CW-1:0]      ady;
    logic [CW-1:0]      adx_q;
    logic [CW-1:0]      ady_q;

    assign dx  = $signed({1'b0, player_x}) - $signed({1'b0, moon_x});
    assign dy  = $signed({1'b0, player_y}) - $signed({1'b0, moon_y});
    assign adx = dx[CW] ? CW'(-dx) : dx[CW-1:0];
    assign ady = dy[CW] ? CW'(-dy) : dy[CW-1:0];

    // capture distances on the sampling tick; valid marks the compare slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            adx_q <= '0;
            ady_q <= '0;
        end else begin
            valid <= tick && !flush;
            if (tick) begin
                adx_q <= adx;
                ady_q <= ady;
            end
        end
    end

    assign collide = (adx_q <= LIM) && (ady_q <= LIM);

endmodule

// File: rtl/moon_hit_ctrl.sv
// Player vs moon hit controller: lives, invulnerability, game over, speed.
// PIXEL_COLLIDE_EN selects sticky pixel-overlap detection over the box test.
module moon_hit_ctrl
    import stg_pkg::*;
#(
    parameter int HIT_RADIUS    = 40,
    parameter int PLAYER_RADIUS = 4,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int SPEED_STEP    = 200000,
    parameter int SPEED_MAX     = 1600000
) (
    input logic             clk,
    input logic             reset_n,
    moon_hit_ctrl_if.slave  bus
);

    localparam logic [LIV_W-1:0] LIVES_V = LIV_W'(LIVES_INIT);
    localparam logic [7:0]       INV_V   = 8'(INVULN_FRAMES);
    localparam logic [SPD_W-1:0] STEP_V  = SPD_W'(SPEED_STEP);
    localparam logic [SPD_W-1:0] MAX_V   = SPD_W'(SPEED_MAX);

    state_t           state;
    logic [LIV_W-1:0] lives;
    logic [SPD_W-1:0] speed;
    logic [7:0]       inv_cnt;
    logic [7:0]       frame_cnt;
    logic             hit_pulse;
    logic             invuln;
    logic             game_over;
    logic             s1_valid;
    logic             s2_busy;
    logic             accept;
    logic             collide;

    assign accept = bus.frame_tick && !bus.restart
                 && !s1_valid && !s2_busy;

    // hold off new ticks during the cycle the evaluation result is shown
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s2_busy <= 1'b0;
        else          s2_busy <= s1_valid && !bus.restart;
    end

`ifdef PIXEL_COLLIDE_EN
    logic pix_flag;
    logic pix_q;
    logic unused_pos;

    assign unused_pos = ^{bus.player_x, bus.player_y,
                          bus.moon_x, bus.moon_y};

    // sticky per-frame pixel overlap, sampled and cleared on each tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_flag <= 1'b0;
            pix_q    <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept)
                pix_q <= pix_flag || (bus.moon_on && bus.player_on);
            if (bus.restart || accept)
                pix_flag <= 1'b0;
            else if (bus.moon_on && bus.player_on)
                pix_flag <= 1'b1;
        end
    end

    assign collide = pix_q;
`else
    logic unused_pix;

    assign unused_pix = bus.moon_on & bus.player_on;

    moon_hit_cmp #(
        .HIT_RADIUS    (HIT_RADIUS),
        .PLAYER_RADIUS (PLAYER_RADIUS)
    ) u_cmp (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (accept),
        .flush    (bus.restart),
        .player_x (bus.player_x),
        .player_y (bus.player_y),
        .moon_x   (bus.moon_x),
        .moon_y   (bus.moon_y),
        .valid    (s1_valid),
        .collide  (collide)
    );
`endif

    // free-running frame counter drives the blink phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            frame_cnt <= '0;
        else if (bus.frame_tick) frame_cnt <= frame_cnt + 8'd1;
    end

    // game FSM: restart beats any pending evaluation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PLAY;
            lives     <= LIVES_V;
            speed     <= '0;
            inv_cnt   <= '0;
            hit_pulse <= 1'b0;
            invuln    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            if (bus.restart) begin
                state     <= PLAY;
                lives     <= LIVES_V;
                speed     <= '0;
                inv_cnt   <= '0;
                invuln    <= 1'b0;
                game_over <= 1'b0;
            end else if (s1_valid) begin
                case (state)
                    PLAY: begin
                        if (collide) begin
                            hit_pulse <= 1'b1;
                            speed     <= sat_add(speed, STEP_V, MAX_V);
                            if (lives == LIV_W'(1)) begin
                                lives     <= '0;
                                state     <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                lives   <= lives - LIV_W'(1);
                                state   <= INVULN;
                                invuln  <= 1'b1;
                                inv_cnt <= INV_V;
                            end
                        end
                    end
                    INVULN: begin
                        inv_cnt <= inv_cnt - 8'd1;
                        if (inv_cnt == 8'd1) begin
                            state  <= PLAY;
                            invuln <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.hit_pulse    = hit_pulse;
    assign bus.lives        = lives;
    assign bus.invuln       = invuln;
    assign bus.player_blink = invuln & frame_cnt[3];
    assign bus.game_over    = game_over;
    assign bus.speed_offset = speed;

endmodule
